// File: rtl/leaf_stream_packetizer.sv
// Leaf transmit packetizer: wraps user words into BFT packets addressed to a
// configured leaf/port, gated by receiver buffer credits.
module leaf_stream_packetizer #(
    parameter int PACKET_BITS           = 49,
    parameter int PAYLOAD_BITS          = 32,
    parameter int NUM_LEAF_BITS         = 5,
    parameter int NUM_PORT_BITS         = 4,
    parameter int NUM_ADDR_BITS         = 7,
    parameter int NUM_BRAM_ADDR_BITS    = 7,
    parameter int FREESPACE_UPDATE_SIZE = 64
) (
    input  logic                     clk_bft,
    input  logic                     reset,
    input  logic                     cfg_we,
    input  logic [NUM_LEAF_BITS-1:0] cfg_dst_leaf,
    input  logic [NUM_PORT_BITS-1:0] cfg_dst_port,
    input  logic [PAYLOAD_BITS-1:0]  din_leaf_user2interface,
    input  logic                     vld_user2interface,
    output logic                     ack_interface2user,
    output logic [PACKET_BITS-1:0]   dout_leaf_interface2bft,
    input  logic                     bft_accept,
    input  logic                     freespace_update,
    output logic                     credit_err
);

    localparam int CREDIT_W = NUM_BRAM_ADDR_BITS + 1;
    localparam logic [CREDIT_W-1:0] CREDIT_MAX = CREDIT_W'(2 ** NUM_BRAM_ADDR_BITS);
    localparam logic [CREDIT_W:0]   UPDATE_AMT = (CREDIT_W + 1)'(FREESPACE_UPDATE_SIZE);

    typedef enum logic {IDLE, SEND} state_t;

    state_t                   state, state_next;
    logic [CREDIT_W-1:0]      credit;
    logic [NUM_ADDR_BITS-1:0] seq_addr;
    logic                     cfg_valid;
    logic [NUM_LEAF_BITS-1:0] dst_leaf;
    logic [NUM_PORT_BITS-1:0] dst_port;
    logic                     xfer;
    logic                     send_done;
    logic [CREDIT_W:0]        credit_raw;

    // Unsaturated credit update, one bit wider so overflow past the buffer depth is visible.
    // Underflow cannot happen: a word is only taken while credit is non-zero.
    function automatic logic [CREDIT_W:0] credit_sum(input logic [CREDIT_W-1:0] cur,
                                                      input logic              take,
                                                      input logic              give);
        logic [CREDIT_W:0] s;
        s = {1'b0, cur};
        if (give) s = s + UPDATE_AMT;
        if (take) s = s - (CREDIT_W + 1)'(1);
        return s;
    endfunction

    // Clamp the credit count at the receiver buffer depth.
    function automatic logic [CREDIT_W-1:0] credit_sat(input logic [CREDIT_W:0] raw);
        return (raw > {1'b0, CREDIT_MAX}) ? CREDIT_MAX : raw[CREDIT_W-1:0];
    endfunction

    assign ack_interface2user = (state == IDLE) && cfg_valid && (credit != '0)
                                && vld_user2interface && !reset;
    assign xfer       = ack_interface2user;
    assign send_done  = (state == SEND) && bft_accept;
    assign credit_raw = credit_sum(credit, xfer, freespace_update);

    // FSM state register.
    always_ff @(posedge clk_bft) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state logic: one packet in flight at a time.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (xfer)       state_next = SEND;
            SEND: if (bft_accept) state_next = IDLE;
            default:              state_next = IDLE;
        endcase
    end

    // Destination registers; a packet already held keeps the header it was built with.
    always_ff @(posedge clk_bft) begin
        if (reset) begin
            cfg_valid <= 1'b0;
            dst_leaf  <= '0;
            dst_port  <= '0;
        end else if (cfg_we) begin
            cfg_valid <= 1'b1;
            dst_leaf  <= cfg_dst_leaf;
            dst_port  <= cfg_dst_port;
        end
    end

    // Output packet register and sequence address; dout is zero whenever nothing is held.
    always_ff @(posedge clk_bft) begin
        if (reset) begin
            dout_leaf_interface2bft <= '0;
            seq_addr                <= '0;
        end else if (xfer) begin
            dout_leaf_interface2bft <= {1'b1, dst_leaf, dst_port, seq_addr, din_leaf_user2interface};
        end else if (send_done) begin
            dout_leaf_interface2bft <= '0;
            seq_addr                <= seq_addr + NUM_ADDR_BITS'(1);
        end
    end

    // Credit counter: paid at word acceptance, refilled by freespace updates, sticky overflow flag.
    always_ff @(posedge clk_bft) begin
        if (reset) begin
            credit     <= CREDIT_MAX;
            credit_err <= 1'b0;
        end else begin
            credit <= credit_sat(credit_raw);
            if (credit_raw > {1'b0, CREDIT_MAX}) credit_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_leaf_stream_packetizer.sv
// Scoreboard bench for leaf_stream_packetizer: stimulus pushes expected packets,
// a negedge monitor pops and compares each packet the BFT accepts.
module tb_leaf_stream_packetizer;

    logic        clk_bft = 1'b0;
    logic        reset = 1'b1;
    logic        cfg_we = 1'b0;
    logic [4:0]  cfg_dst_leaf = '0;
    logic [3:0]  cfg_dst_port = '0;
    logic [31:0] din_leaf_user2interface = '0;
    logic        vld_user2interface = 1'b0;
    logic        ack_interface2user;
    logic [48:0] dout_leaf_interface2bft;
    logic        bft_accept = 1'b0;
    logic        freespace_update = 1'b0;
    logic        credit_err;

    leaf_stream_packetizer dut (
        .clk_bft                 (clk_bft),
        .reset                   (reset),
        .cfg_we                  (cfg_we),
        .cfg_dst_leaf            (cfg_dst_leaf),
        .cfg_dst_port            (cfg_dst_port),
        .din_leaf_user2interface (din_leaf_user2interface),
        .vld_user2interface      (vld_user2interface),
        .ack_interface2user      (ack_interface2user),
        .dout_leaf_interface2bft (dout_leaf_interface2bft),
        .bft_accept              (bft_accept),
        .freespace_update        (freespace_update),
        .credit_err              (credit_err)
    );

    always #5 clk_bft = ~clk_bft;

    int          n_checks = 0;
    int          n_pass = 0;
    logic [48:0] sb_q[$];
    logic [4:0]  leaf_m = '0;
    logic [3:0]  port_m = '0;
    logic [6:0]  seq_m = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Monitor: every packet taken by the BFT must match the oldest expected packet.
    always @(negedge clk_bft) begin
        if (!reset && dout_leaf_interface2bft[48] && bft_accept) begin
            if (sb_q.size() == 0) check("unexpected_pkt", {15'd0, dout_leaf_interface2bft}, 64'd0);
            else check("pkt", {15'd0, dout_leaf_interface2bft}, {15'd0, sb_q.pop_front()});
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        @(posedge clk_bft); #1;
        reset = 1'b1; vld_user2interface = 1'b0; bft_accept = 1'b0;
        freespace_update = 1'b0; cfg_we = 1'b0;
        repeat (2) @(posedge clk_bft);
        #1 reset = 1'b0;
        seq_m = '0;
    endtask

    task automatic cfg(input logic [4:0] leaf, input logic [3:0] port);
        @(posedge clk_bft); #1;
        cfg_we = 1'b1; cfg_dst_leaf = leaf; cfg_dst_port = port;
        @(posedge clk_bft); #1;
        cfg_we = 1'b0;
        leaf_m = leaf; port_m = port;
    endtask

    task automatic send_word(input logic [31:0] data, input int hold, input logic fsu);
        logic [48:0] exp;
        @(posedge clk_bft); #1;
        vld_user2interface = 1'b1; din_leaf_user2interface = data;
        bft_accept = 1'b0; freespace_update = fsu;
        @(negedge clk_bft);
        check("ack_word", {63'd0, ack_interface2user}, 64'd1);
        exp = {1'b1, leaf_m, port_m, seq_m, data};
        sb_q.push_back(exp);
        @(posedge clk_bft); #1;
        vld_user2interface = 1'b0; freespace_update = 1'b0;
        for (int i = 0; i < hold; i++) begin
            vld_user2interface = 1'b1; din_leaf_user2interface = ~data;
            @(negedge clk_bft);
            check("hold_dout", {15'd0, dout_leaf_interface2bft}, {15'd0, exp});
            check("hold_ack", {63'd0, ack_interface2user}, 64'd0);
            @(posedge clk_bft); #1;
        end
        vld_user2interface = 1'b0; bft_accept = 1'b1;
        @(posedge clk_bft); #1;
        bft_accept = 1'b0;
        seq_m = seq_m + 7'd1;
    endtask

    task automatic expect_stall(input int n);
        @(posedge clk_bft); #1;
        vld_user2interface = 1'b1; din_leaf_user2interface = 32'h0BAD_0BAD;
        for (int i = 0; i < n; i++) begin
            @(negedge clk_bft);
            check("stall_ack", {63'd0, ack_interface2user}, 64'd0);
            @(posedge clk_bft); #1;
        end
        vld_user2interface = 1'b0;
    endtask

    task automatic pulse_fsu();
        @(posedge clk_bft); #1;
        freespace_update = 1'b1;
        @(posedge clk_bft); #1;
        freespace_update = 1'b0;
    endtask

    initial begin
        // Reset state, with vld high to show ack is blocked before configuration
        do_reset();
        vld_user2interface = 1'b1;
        @(negedge clk_bft);
        check("rst_dout", {15'd0, dout_leaf_interface2bft}, 64'd0);
        check("rst_ack", {63'd0, ack_interface2user}, 64'd0);
        check("rst_err", {63'd0, credit_err}, 64'd0);
        vld_user2interface = 1'b0;

        // First packet: leaf 3, port 2, seq 0
        cfg(5'd3, 4'd2);
        send_word(32'hDEADBEEF, 0, 1'b0);
        // Held packet stays stable for 5 cycles, carries seq 1
        send_word(32'h12345678, 5, 1'b0);

        // Credit exhaustion, refill, and sequence wrap over 192 packets
        do_reset();
        cfg(5'd7, 4'd9);
        for (int i = 0; i < 128; i++) send_word(32'hA000_0000 + i, 0, 1'b0);
        expect_stall(3);
        pulse_fsu();
        for (int i = 0; i < 64; i++) send_word(32'hB000_0000 + i, 0, 1'b0);
        expect_stall(2);
        check("err_after_refill", {63'd0, credit_err}, 64'd0);

        // Update coinciding with a transfer nets +63: 64 + 63 = 127 more words before stall
        do_reset();
        cfg(5'd31, 4'd15);
        for (int i = 0; i < 64; i++) send_word(32'hC000_0000 + i, 0, 1'b0);
        send_word(32'hC0DE_0001, 0, 1'b1);
        for (int i = 0; i < 127; i++) send_word(32'hC100_0000 + i, 0, 1'b0);
        expect_stall(2);
        check("err_sim_update", {63'd0, credit_err}, 64'd0);

        // Update at full credit: saturate at 128 and set sticky error
        do_reset();
        pulse_fsu();
        @(negedge clk_bft);
        check("err_set", {63'd0, credit_err}, 64'd1);
        cfg(5'd1, 4'd1);
        for (int i = 0; i < 128; i++) send_word(32'hD000_0000 + i, 0, 1'b0);
        expect_stall(2);
        check("err_sticky", {63'd0, credit_err}, 64'd1);
        do_reset();
        @(negedge clk_bft);
        check("err_cleared", {63'd0, credit_err}, 64'd0);

        // Reset while a packet is held: packet dropped, config and credits restored
        cfg(5'd1, 4'd4);
        @(posedge clk_bft); #1;
        vld_user2interface = 1'b1; din_leaf_user2interface = 32'hCAFEF00D;
        @(negedge clk_bft);
        check("r6_ack", {63'd0, ack_interface2user}, 64'd1);
        @(posedge clk_bft); #1;
        @(negedge clk_bft);
        check("r6_held", {15'd0, dout_leaf_interface2bft}, {15'd0, 1'b1, 5'd1, 4'd4, 7'd0, 32'hCAFEF00D});
        @(posedge clk_bft); #1;
        reset = 1'b1;
        @(negedge clk_bft);
        check("r6_ack_in_rst", {63'd0, ack_interface2user}, 64'd0);
        @(posedge clk_bft); #1;
        reset = 1'b0;
        seq_m = '0;
        @(negedge clk_bft);
        check("r6_dout", {15'd0, dout_leaf_interface2bft}, 64'd0);
        check("r6_cfg_cleared", {63'd0, ack_interface2user}, 64'd0);
        vld_user2interface = 1'b0;
        cfg(5'd1, 4'd4);
        for (int i = 0; i < 128; i++) send_word(32'h5500_0000 + i, 0, 1'b0);
        expect_stall(2);

        repeat (3) @(posedge clk_bft);
        check("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
